if_stage: RTL

- Instruction-fetch stage directly upstream of the main decoder (CONTROL).
- Owns the PC and runs a req/ack handshake with instruction memory.
- Buffers fetched words through a one-entry skid buffer into the IF/ID output register.
- Presents opcode/funct to the decoder.
- Takes PC redirects (branch/jump/jal/jr targets) from downstream and flushes wrong-path words.

---
 rtl/if_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage that owns the PC, runs a req/ack handshake with
// instruction memory, buffers words through a one-entry skid buffer into the IF/ID
// register, and flushes wrong-path words on a PC redirect.
//   clk, nrst           : rising-edge clock, synchronous active-low reset
//   imem_req/imem_addr  : fetch request and word-aligned address (held until ack)
//   imem_ack/imem_rdata : one-cycle ack pulse with the fetched word
//   stall               : decode cannot accept; IF/ID holds its contents
//   redirect_valid/_pc  : one-cycle redirect pulse and new PC (bits [1:0] ignored)
//   instr_valid, instr, instr_pc, pc_plus4, opcode, funct : IF/ID outputs to CONTROL
//   Optional macro IF_STAGE_PERF_CNT_EN adds perf_fetch_cnt and perf_bubble_cnt.
module if_stage #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              nrst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [5:0]        opcode,
  output logic [5:0]        funct
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;
  state_t r_state, w_state;
  logic [ADDR_W-1:0] r_pc, w_pc;
  logic [ADDR_W-1:0] r_drop_addr, w_drop_addr;
  logic r_skid_v, w_skid_v;
  logic [31:0] r_skid_d, w_skid_d;
  logic [ADDR_W-1:0] r_skid_pc, w_skid_pc;
  logic r_valid, w_valid;
  logic [31:0] r_instr, w_instr;
  logic [ADDR_W-1:0] r_ipc, w_ipc;
  logic [ADDR_W-1:0] r_ipc4, w_ipc4;
  logic w_ack;
  logic w_load;
  logic [ADDR_W-1:0] w_redir_pc;
  assign imem_req = (r_state == S_REQ) || (r_state == S_DROP);
  // While dropping, the old address stays on the bus even though the PC has moved on.
  assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign instr_valid = r_valid;
  assign instr = r_instr;
  assign instr_pc = r_ipc;
  assign pc_plus4 = r_ipc4;
  assign opcode = r_instr[31:26];
  assign funct = r_instr[5:0];
  always_comb begin
    // Only acks in REQ deliver a word; acks in DROP are wrong-path, in IDLE stale.
    w_ack = imem_ack && (r_state == S_REQ);
    w_load = !r_valid || !stall;
    w_redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
    w_state = r_state;
    w_pc = r_pc;
    w_drop_addr = r_drop_addr;
    w_skid_v = r_skid_v;
    w_skid_d = r_skid_d;
    w_skid_pc = r_skid_pc;
    w_valid = r_valid;
    w_instr = r_instr;
    w_ipc = r_ipc;
    w_ipc4 = r_ipc4;
    if (w_ack) w_pc = r_pc + ADDR_W'(4);
    if (w_load) begin
      if (r_skid_v) begin
        w_valid = 1'b1;
        w_instr = r_skid_d;
        w_ipc = r_skid_pc;
        w_ipc4 = r_skid_pc + ADDR_W'(4);
        w_skid_v = 1'b0;
      end else if (w_ack) begin
        w_valid = 1'b1;
        w_instr = imem_rdata;
        w_ipc = r_pc;
        w_ipc4 = r_pc + ADDR_W'(4);
      end else begin
        w_valid = 1'b0;
        w_instr = '0;
      end
    end
    // An acked word that did not go straight to IF/ID parks in the skid buffer.
    if (w_ack && !(w_load && !r_skid_v)) begin
      w_skid_v = 1'b1;
      w_skid_d = imem_rdata;
      w_skid_pc = r_pc;
    end
    case (r_state)
      S_IDLE: w_state = S_REQ;
      S_REQ: w_state = (w_ack && w_skid_v) ? S_HOLD : S_REQ;
      S_HOLD: w_state = w_skid_v ? S_HOLD : S_REQ;
      default: w_state = imem_ack ? S_REQ : S_DROP;
    endcase
    // Redirect wins over stall and ack; an ack in the same cycle is the wrong-path word.
    if (redirect_valid) begin
      w_pc = w_redir_pc;
      w_valid = 1'b0;
      w_instr = '0;
      w_skid_v = 1'b0;
      w_state = (imem_req && !imem_ack) ? S_DROP : S_REQ;
      w_drop_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_pc <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
      r_skid_pc <= '0;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ipc <= '0;
      r_ipc4 <= '0;
    end else begin
      r_state <= w_state;
      r_pc <= w_pc;
      r_drop_addr <= w_drop_addr;
      r_skid_v <= w_skid_v;
      r_skid_d <= w_skid_d;
      r_skid_pc <= w_skid_pc;
      r_valid <= w_valid;
      r_instr <= w_instr;
      r_ipc <= w_ipc;
      r_ipc4 <= w_ipc4;
    end
  end
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;
  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_fetch_cnt <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_ack && !redirect_valid) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (!r_valid) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end
`endif
endmodule
